// File: rtl/reg_file_mp_if.sv
// Register-file bus: two writeback ports, one reservation port, NUM_RD read ports
// and the registered busy count.
interface reg_file_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
);
    logic [1:0]                   wr_en;
    logic [2*ADDR_WIDTH-1:0]      wr_addr;
    logic [2*DATA_WIDTH-1:0]      wr_data;
    logic                         rsv_en;
    logic [ADDR_WIDTH-1:0]        rsv_addr;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic [ADDR_WIDTH:0]          busy_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: two write ports, write-first read bypass,
// and a per-register busy scoreboard with a registered population count.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
) (
    input logic          clk,
    input logic          reset,
    reg_file_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]        mem [DEPTH];
    logic [DEPTH-1:0]             busy_q;
    logic [DEPTH-1:0]             busy_nxt;
    logic [ADDR_WIDTH:0]          busy_cnt_q;

    logic [ADDR_WIDTH-1:0]        wa0, wa1;
    logic [DATA_WIDTH-1:0]        wd0, wd1;
    logic                         we0, we1;
    logic                         rsv_ok;

    logic [ADDR_WIDTH-1:0]        ra;
    logic                         hit0, hit1;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_c;
    logic [NUM_RD-1:0]            rd_busy_c;

    function automatic logic [ADDR_WIDTH:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_WIDTH:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++)
            c = c + {{ADDR_WIDTH{1'b0}}, v[i]};
        return c;
    endfunction

    assign wa0 = bus.wr_addr[0 +: ADDR_WIDTH];
    assign wa1 = bus.wr_addr[ADDR_WIDTH +: ADDR_WIDTH];
    assign wd0 = bus.wr_data[0 +: DATA_WIDTH];
    assign wd1 = bus.wr_data[DATA_WIDTH +: DATA_WIDTH];

    // Register 0 is hardwired: writes and reservations to it never qualify.
    assign we0    = bus.wr_en[0] && (wa0 != '0);
    assign we1    = bus.wr_en[1] && (wa1 != '0);
    assign rsv_ok = bus.rsv_en && (bus.rsv_addr != '0);

    // Reservation is applied last so a same-edge reserve beats the clearing write.
    always_comb begin
        busy_nxt    = busy_q;
        busy_nxt[0] = 1'b0;
        if (we0)    busy_nxt[wa0] = 1'b0;
        if (we1)    busy_nxt[wa1] = 1'b0;
        if (rsv_ok) busy_nxt[bus.rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (we0) mem[wa0] <= wd0;
            if (we1) mem[wa1] <= wd1;
            busy_q     <= busy_nxt;
            busy_cnt_q <= popcount(busy_nxt);
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        ra        = '0;
        hit0      = 1'b0;
        hit1      = 1'b0;
        for (int j = 0; j < NUM_RD; j++) begin
            ra   = bus.rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            hit1 = we1 && (wa1 == ra);
            hit0 = we0 && (wa0 == ra);
            if (ra != '0) begin
                if (hit1)
                    rd_data_c[j*DATA_WIDTH +: DATA_WIDTH] = wd1;
                else if (hit0)
                    rd_data_c[j*DATA_WIDTH +: DATA_WIDTH] = wd0;
                else
                    rd_data_c[j*DATA_WIDTH +: DATA_WIDTH] = mem[ra];
                rd_busy_c[j] = busy_q[ra] && !(hit0 || hit1);
            end
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus randomized traffic
// against an array-based reference model.
module tb_reg_file_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) bus ();

    reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_busy[DEPTH];

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]  = '0;
            ref_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rsv_en   = 1'b0;
        bus.rsv_addr = '0;
    endtask

    task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en[k]           = 1'b1;
        bus.wr_addr[k*AW +: AW] = a;
        bus.wr_data[k*DW +: DW] = d;
    endtask

    task automatic set_rd(input int j, input logic [AW-1:0] a);
        bus.rd_addr[j*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] get_rd(input int j);
        return bus.rd_data[j*DW +: DW];
    endfunction

    function automatic bit written_now(input logic [AW-1:0] a);
        return (bus.wr_en[0] && bus.wr_addr[0 +: AW] == a) ||
               (bus.wr_en[1] && bus.wr_addr[AW +: AW] == a);
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (bus.wr_en[1] && bus.wr_addr[AW +: AW] == a) return bus.wr_data[DW +: DW];
        if (bus.wr_en[0] && bus.wr_addr[0 +: AW] == a) return bus.wr_data[0 +: DW];
        return ref_mem[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        return ref_busy[a] && !written_now(a);
    endfunction

    function automatic logic [AW:0] exp_cnt();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(ref_busy[i]);
        return (AW+1)'(c);
    endfunction

    // Reference update for one rising edge: writes in port order, clears, then reserve.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (bus.wr_en[k] && bus.wr_addr[k*AW +: AW] != 0) begin
                ref_mem[bus.wr_addr[k*AW +: AW]]  = bus.wr_data[k*DW +: DW];
                ref_busy[bus.wr_addr[k*AW +: AW]] = 1'b0;
            end
        end
        if (bus.rsv_en && bus.rsv_addr != 0) ref_busy[bus.rsv_addr] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_power_on();
        reset = 1'b1;
        idle();
        bus.rd_addr = '0;
        #2 reset = 1'b0;
        model_clear();
        @(negedge clk);
        set_wr(0, 5'd5, 32'hCAFEF00D);
        bus.rsv_en = 1'b1;
        bus.rsv_addr = 5'd5;
        @(posedge clk);
        @(negedge clk);
        idle();
        set_rd(0, 5'd5);
        #1;
        n_checks++;
        if (get_rd(0) !== 32'h0) $display("FAIL por_write_ignored got %h exp %h", get_rd(0), 32'h0);
        else n_pass++;
        n_checks++;
        if (bus.busy_cnt !== '0) $display("FAIL por_busy_cnt got %0d exp 0", bus.busy_cnt);
        else n_pass++;
        n_checks++;
        if (bus.rd_busy[0] !== 1'b0) $display("FAIL por_rd_busy got %b exp 0", bus.rd_busy[0]);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_bypass();
        idle();
        set_wr(0, 5'd3, 32'h12345678);
        set_rd(0, 5'd3);
        set_rd(1, 5'd0);
        #1;
        n_checks++;
        if (get_rd(0) !== 32'h12345678) $display("FAIL bypass_r3 got %h exp %h", get_rd(0), 32'h12345678);
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if (get_rd(0) !== 32'h12345678) $display("FAIL stored_r3 got %h exp %h", get_rd(0), 32'h12345678);
        else n_pass++;
    endtask

    task automatic test_collision();
        idle();
        set_wr(0, 5'd7, 32'hAAAA0000);
        set_wr(1, 5'd7, 32'h5555FFFF);
        set_rd(0, 5'd7);
        set_rd(1, 5'd7);
        #1;
        n_checks++;
        if (get_rd(1) !== 32'h5555FFFF) $display("FAIL collide_bypass got %h exp %h", get_rd(1), 32'h5555FFFF);
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if (get_rd(0) !== 32'h5555FFFF) $display("FAIL collide_stored got %h exp %h", get_rd(0), 32'h5555FFFF);
        else n_pass++;
    endtask

    task automatic test_reg0();
        logic [AW:0] cnt_before;
        cnt_before = exp_cnt();
        idle();
        set_wr(0, 5'd0, 32'hFFFFFFFF);
        set_wr(1, 5'd0, 32'hFFFFFFFF);
        bus.rsv_en = 1'b1;
        bus.rsv_addr = 5'd0;
        set_rd(0, 5'd0);
        #1;
        n_checks++;
        if (get_rd(0) !== 32'h0) $display("FAIL r0_bypass got %h exp 0", get_rd(0));
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if (get_rd(0) !== 32'h0 || bus.rd_busy[0] !== 1'b0)
            $display("FAIL r0_stored got %h/%b exp 0/0", get_rd(0), bus.rd_busy[0]);
        else n_pass++;
        n_checks++;
        if (bus.busy_cnt !== cnt_before) $display("FAIL r0_busy_cnt got %0d exp %0d", bus.busy_cnt, cnt_before);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        idle();
        bus.rsv_en = 1'b1;
        bus.rsv_addr = 5'd9;
        set_rd(0, 5'd9);
        #1;
        n_checks++;
        if (bus.rd_busy[0] !== 1'b0) $display("FAIL rsv_same_cycle got %b exp 0", bus.rd_busy[0]);
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.rd_busy[0] !== 1'b1 || bus.busy_cnt !== 6'd1)
            $display("FAIL rsv_r9 got busy %b cnt %0d exp 1 1", bus.rd_busy[0], bus.busy_cnt);
        else n_pass++;
        set_wr(1, 5'd9, 32'h42);
        #1;
        n_checks++;
        if (bus.rd_busy[0] !== 1'b0 || get_rd(0) !== 32'h42)
            $display("FAIL wb_r9 got busy %b data %h exp 0 00000042", bus.rd_busy[0], get_rd(0));
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.busy_cnt !== 6'd0) $display("FAIL wb_r9_cnt got %0d exp 0", bus.busy_cnt);
        else n_pass++;
    endtask

    task automatic test_rsv_write();
        idle();
        bus.rsv_en = 1'b1;
        bus.rsv_addr = 5'd4;
        set_wr(0, 5'd4, 32'h99);
        set_rd(1, 5'd4);
        tick();
        idle();
        #1;
        n_checks++;
        if (get_rd(1) !== 32'h99 || bus.rd_busy[1] !== 1'b1 || bus.busy_cnt !== 6'd1)
            $display("FAIL rsv_wr_r4 got %h/%b/%0d exp 00000099/1/1", get_rd(1), bus.rd_busy[1], bus.busy_cnt);
        else n_pass++;
        bus.rsv_en = 1'b1;
        bus.rsv_addr = 5'd4;
        tick();
        idle();
        #1;
        n_checks++;
        if (bus.busy_cnt !== 6'd1) $display("FAIL rersv_cnt got %0d exp 1", bus.busy_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        idle();
        set_wr(0, 5'd5, 32'hDEADBEEF);
        tick();
        idle();
        bus.rsv_en = 1'b1;
        bus.rsv_addr = 5'd5;
        tick();
        idle();
        set_rd(0, 5'd5);
        #1;
        n_checks++;
        if (get_rd(0) !== 32'hDEADBEEF || bus.rd_busy[0] !== 1'b1)
            $display("FAIL pre_reset_r5 got %h/%b exp deadbeef/1", get_rd(0), bus.rd_busy[0]);
        else n_pass++;
        #1 reset = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (get_rd(0) !== 32'h0 || bus.rd_busy[0] !== 1'b0 || bus.busy_cnt !== 6'd0)
            $display("FAIL async_reset got %h/%b/%0d exp 0/0/0", get_rd(0), bus.rd_busy[0], bus.busy_cnt);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int it = 0; it < 300; it++) begin
            idle();
            bus.wr_en    = 2'($urandom_range(0, 3));
            bus.wr_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            bus.wr_data  = {32'($urandom), 32'($urandom)};
            bus.rsv_en   = 1'($urandom_range(0, 1));
            bus.rsv_addr = 5'($urandom_range(0, 7));
            bus.rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            #1;
            for (int j = 0; j < NR; j++) begin
                a = bus.rd_addr[j*AW +: AW];
                n_checks++;
                if (get_rd(j) !== exp_data(a) || bus.rd_busy[j] !== exp_busy(a))
                    $display("FAIL rand_rd%0d it %0d addr %0d got %h/%b exp %h/%b",
                             j, it, a, get_rd(j), bus.rd_busy[j], exp_data(a), exp_busy(a));
                else n_pass++;
            end
            n_checks++;
            if (bus.busy_cnt !== exp_cnt())
                $display("FAIL rand_cnt it %0d got %0d exp %0d", it, bus.busy_cnt, exp_cnt());
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        test_power_on();
        test_bypass();
        test_collision();
        test_reg0();
        test_scoreboard();
        test_rsv_write();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
